// File: rtl/design_pkg.sv
// Shared types and sizing helpers for the operand issue queue.
package design_pkg;

    // Issue FSM: IDLE may issue at any edge; COOL waits out the inter-issue gap.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        COOL = 1'b1
    } state_e;

    // Occupancy counters need one extra bit to tell full from empty.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned DEFAULT_DEPTH   = 4;
    localparam int unsigned DEFAULT_COUNT_W = $clog2(DEFAULT_DEPTH) + 1;

endpackage

// File: rtl/sync_fifo_ram.sv
// Register-based synchronous FIFO with occupancy count and flush.
module sync_fifo_ram import design_pkg::*; #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_flush,
    input  logic                            i_push,
    input  logic [DW-1:0]                   i_wdata,
    input  logic                            i_pop,
    output logic [DW-1:0]                   o_rdata,
    output logic [count_width(DEPTH)-1:0]   o_count,
    output logic                            o_full,
    output logic                            o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = count_width(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    // Flush and reset both swallow any same-cycle push or pop.
    assign w_push  = i_push && !o_full && !i_flush && !i_rst;
    assign w_pop   = i_pop && !o_empty && !i_flush && !i_rst;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/operand_issue_queue.sv
// Buffers operand pairs and issues them as spaced one-cycle start pulses.
module operand_issue_queue import design_pkg::*; #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned GAP   = 2
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_in_valid,
    output logic                            o_in_ready,
    input  logic [W-1:0]                    i_in_a,
    input  logic [W-1:0]                    i_in_b,
    input  logic                            i_flush,
    output logic                            o_start,
    output logic [W-1:0]                    o_a,
    output logic [W-1:0]                    o_b,
    output logic [count_width(DEPTH)-1:0]   o_count
);

    localparam int unsigned   GW       = $clog2(GAP + 1);
    localparam logic [GW-1:0] COOL_LD  = GW'(GAP - 1);

    state_e         r_state;
    state_e         w_state_d;
    logic [GW-1:0]  r_cool;
    logic [GW-1:0]  w_cool_d;
    logic           r_start;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           w_issue;
    logic           w_push;
    logic           w_full;
    logic           w_empty;
    logic [2*W-1:0] w_rdata;

    // Ready depends only on registered occupancy, never on a same-cycle pop.
    assign o_in_ready = !w_full && !i_rst;
    assign w_push     = i_in_valid && o_in_ready;
    assign o_start    = r_start;
    assign o_a        = r_a;
    assign o_b        = r_b;

    sync_fifo_ram #(
        .DW    (2 * W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_flush),
        .i_push  (w_push),
        .i_wdata ({i_in_a, i_in_b}),
        .i_pop   (w_issue),
        .o_rdata (w_rdata),
        .o_count (o_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // State register: FSM state and cooldown counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cool  <= '0;
        end else begin
            r_state <= w_state_d;
            r_cool  <= w_cool_d;
        end
    end

    // Next state: cooldown keeps counting through a flush so spacing is preserved.
    always_comb begin
        w_state_d = r_state;
        w_cool_d  = r_cool;
        case (r_state)
            IDLE: begin
                if (w_issue) begin
                    w_cool_d  = COOL_LD;
                    w_state_d = (GAP > 1) ? COOL : IDLE;
                end
            end
            COOL: begin
                if (r_cool != '0) begin
                    w_cool_d = r_cool - GW'(1);
                end else if (w_issue) begin
                    w_cool_d = COOL_LD;
                end else begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Output decode: issue when the gap has elapsed and a pair is waiting.
    always_comb begin
        w_issue = !w_empty && !i_flush && ((r_state == IDLE) || (r_cool == '0));
    end

    // Registered outputs; a/b change only on an issue edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_start <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_start <= w_issue;
            if (w_issue) begin
                r_a <= w_rdata[2*W-1:W];
                r_b <= w_rdata[W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_operand_issue_queue.sv
// Directed bench with a scoreboard of accepted pairs checked at every issue.
module tb_operand_issue_queue;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int GAP0  = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_ready;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [CW-1:0] count;

    logic          v1 = 1'b0;
    logic [W-1:0]  a1i = '0;
    logic [W-1:0]  b1i = '0;
    logic          ready1;
    logic          start1;
    logic [W-1:0]  a1o;
    logic [W-1:0]  b1o;
    logic [CW-1:0] count1;

    int checks = 0;
    int errors = 0;
    int n_issued = 0;
    int since = GAP0;
    logic mon_en = 1'b0;
    logic p_rst = 1'b1;
    logic [W-1:0] last_a = '0;
    logic [W-1:0] last_b = '0;
    logic [2*W-1:0] sb [$];
    logic [2*W-1:0] exp_pair;

    always #5 clk = ~clk;

    operand_issue_queue #(.W(W), .DEPTH(DEPTH), .GAP(GAP0)) u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_in_a     (in_a),
        .i_in_b     (in_b),
        .i_flush    (flush),
        .o_start    (start),
        .o_a        (a),
        .o_b        (b),
        .o_count    (count)
    );

    operand_issue_queue #(.W(W), .DEPTH(DEPTH), .GAP(1)) u_dut_g1 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_in_valid (v1),
        .o_in_ready (ready1),
        .i_in_a     (a1i),
        .i_in_b     (b1i),
        .i_flush    (1'b0),
        .o_start    (start1),
        .o_a        (a1o),
        .o_b        (b1o),
        .o_count    (count1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor on the GAP=2 instance: outputs reflect the previous edge,
    // then the handshake for the coming edge is recorded.
    always @(negedge clk) begin
        if (mon_en) begin
            if (p_rst) begin
                chk("rst_start", start, 0);
                chk("rst_a", a, 0);
                chk("rst_b", b, 0);
                sb.delete();
                last_a = '0;
                last_b = '0;
                since  = GAP0;
            end else if (start) begin
                if (sb.size() == 0) begin
                    chk("unexpected_start", start, 0);
                end else begin
                    exp_pair = sb.pop_front();
                    chk("issue_a", a, exp_pair[2*W-1:W]);
                    chk("issue_b", b, exp_pair[W-1:0]);
                end
                chk("spacing_ok", 32'(since + 1 >= GAP0), 1);
                n_issued++;
                last_a = a;
                last_b = b;
                since  = 0;
            end else begin
                chk("hold_a", a, last_a);
                chk("hold_b", b, last_b);
                since++;
            end
            chk("count_model", count, sb.size());
            chk("ready_model", in_ready, 32'((sb.size() != DEPTH) && !rst));
            p_rst = rst;
            if (rst || flush) begin
                sb.delete();
            end else if (in_valid && in_ready) begin
                sb.push_back({in_a, in_b});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] y;
        logic [W-1:0] va;
        logic         acc;
        logic         saw_full;
        int           idx;
        int           base;
        logic         exp_s;

        // Reset
        rst = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();
        chk("reset_start", start, 0);
        chk("reset_a", a, 0);
        chk("reset_b", b, 0);
        chk("reset_count", count, 0);
        chk("reset_ready", in_ready, 0);
        chk("reset_start_g1", start1, 0);
        rst = 1'b0;
        #1;
        chk("release_ready", in_ready, 1);
        chk("release_ready_g1", ready1, 1);

        // Single pair: one cycle in queue, then a one-cycle start
        in_valid = 1'b1;
        in_a = 16'h0003;
        in_b = 16'h0005;
        tick();
        chk("sp_count1", count, 1);
        chk("sp_nostart", start, 0);
        in_valid = 1'b0;
        tick();
        chk("sp_start", start, 1);
        chk("sp_a", a, 16'h0003);
        chk("sp_b", b, 16'h0005);
        chk("sp_count0", count, 0);
        y = a + b;
        chk("sp_sum", y, 16'h0008);
        tick();
        chk("sp_pulse", start, 0);

        // Backlog: four pairs, starts exactly GAP apart
        repeat (3) tick();
        for (int e = 0; e < 9; e++) begin
            if (e < 4) begin
                in_valid = 1'b1;
                in_a = 16'h1000 + 16'(e);
                in_b = 16'h2000 + 16'(e);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            exp_s = (e % 2 == 1) && (e < 8);
            chk("bl_start", start, 32'(exp_s));
            if (exp_s) chk("bl_a", a, 16'h1000 + 16'((e - 1) / 2));
        end

        // Full: push every cycle, hold an offer until it is accepted
        repeat (3) tick();
        idx = 0;
        saw_full = 1'b0;
        base = n_issued;
        for (int c = 0; c < 12; c++) begin
            va = (idx == 0) ? 16'hFFFF : (idx == 1) ? 16'h0000 : 16'hA000 + 16'(idx);
            in_valid = 1'b1;
            in_a = va;
            in_b = ~va;
            acc = in_ready;
            if (count == CW'(DEPTH)) begin
                saw_full = 1'b1;
                chk("full_ready_low", in_ready, 0);
            end
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        repeat (12) tick();
        chk("full_drained", count, 0);
        chk("full_seen", saw_full, 1);
        chk("full_wrap", 32'(idx > DEPTH), 1);
        chk("full_all_issued", n_issued - base, idx);

        // Flush with three queued and a concurrent push
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a = 16'h5000 + 16'(i);
            in_b = 16'h5100 + 16'(i);
            tick();
        end
        chk("fl_count_pre", count, 3);
        flush = 1'b1;
        in_a = 16'hDEAD;
        in_b = 16'hBEEF;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_count", count, 0);
        chk("fl_start", start, 0);
        chk("fl_a", a, 16'h5001);
        chk("fl_b", b, 16'h5101);
        repeat (5) begin
            tick();
            chk("fl_idle", start, 0);
            chk("fl_count0", count, 0);
            chk("fl_hold_a", a, 16'h5001);
        end

        // Reset mid-operation with two queued and cooling down
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_a = 16'h6000 + 16'(i);
            in_b = 16'h6100 + 16'(i);
            tick();
        end
        chk("rs_count_pre", count, 2);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rs_ready_during", in_ready, 0);
        tick();
        chk("rs_start", start, 0);
        chk("rs_a", a, 0);
        chk("rs_b", b, 0);
        chk("rs_count", count, 0);
        chk("rs_ready_held", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("rs_ready_rel", in_ready, 1);
        in_valid = 1'b1;
        in_a = 16'h7777;
        in_b = 16'h8888;
        tick();
        in_valid = 1'b0;
        chk("rs_count1", count, 1);
        chk("rs_nostart", start, 0);
        tick();
        chk("rs_start_new", start, 1);
        chk("rs_a_new", a, 16'h7777);
        chk("rs_b_new", b, 16'h8888);
        tick();

        // GAP=1 instance: back-to-back issue
        repeat (2) tick();
        for (int e = 0; e < 5; e++) begin
            if (e < 3) begin
                v1 = 1'b1;
                a1i = 16'h0100 + 16'(e);
                b1i = 16'h0200 + 16'(e);
            end else begin
                v1 = 1'b0;
            end
            tick();
            exp_s = (e >= 1) && (e <= 3);
            chk("g1_start", start1, 32'(exp_s));
            if (exp_s) begin
                chk("g1_a", a1o, 16'h0100 + 16'(e - 1));
                chk("g1_b", b1o, 16'h0200 + 16'(e - 1));
            end
        end
        chk("g1_count", count1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
